i_cache_nway: RTL and testbench

Parametrised, read-only, N-way set-associative instruction cache with tree pseudo-LRU replacement and a sequential invalidate-all (fence.i) engine. It sits between the CPU fetch stage and the arbiter: 32-bit word reads on the CPU side, 256-bit line fills on the physical-memory side. It replaces the fixed 2-way I-cache and adds configurable ways and sets, fill-order victim selection, and flush support. It has no write path.

---
 rtl/i_cache_pkg.sv | 68 ++++++
 rtl/i_cache_nway_if.sv | 36 +++
 rtl/i_cache_plru.sv | 60 ++++++
 rtl/i_cache_nway.sv | 191 +++++++++++++++++++
 tb/tb_i_cache_nway.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/i_cache_pkg.sv
// ----------------------------------------------------------------------------
// i_cache_pkg
// Shared types and helpers for the N-way instruction cache:
//   state_t      - controller states (IDLE, FILL, FLUSH)
//   line_t       - one 256-bit cache line
//   plru_victim  - tree pseudo-LRU victim walk for one set
//   plru_update  - tree pseudo-LRU update after an access to one way
// The PLRU helpers work on a vector sized for the largest supported
// associativity (32 ways). The caller passes its real way count.
// ----------------------------------------------------------------------------
package i_cache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int LINE_W          = 256;
   localparam int PLRU_MAX_LEVELS = 5;
   localparam int PLRU_MAX_WAYS   = 1 << PLRU_MAX_LEVELS;

   typedef logic [LINE_W-1:0]          line_t;
   typedef logic [PLRU_MAX_WAYS-2:0]   plru_vec_t;
   typedef logic [PLRU_MAX_LEVELS-1:0] plru_way_t;

   // Tree nodes are heap-ordered: node n has children 2n+1 (bit 0) and
   // 2n+2 (bit 1). The root decides the LSB of the way index, so the
   // tree interleaves the ways: the root picks even or odd ways, the next
   // level picks bit 1, and so on. A node bit names the subtree holding
   // the next victim.
   function automatic plru_way_t plru_victim(input plru_vec_t bits, input int ways);
      logic [4:0] node;
      plru_way_t  way;
      logic       dir;
      node = '0;
      way  = '0;
      for (int d = 0; d < PLRU_MAX_LEVELS; d++) begin
         if ((ways >> (d + 1)) != 0) begin
            dir  = bits[node];
            way  = way | (plru_way_t'(dir) << d);
            node = {node[3:0], 1'b0} + 5'd1 + {4'd0, dir};
         end
      end
      return way;
   endfunction

   // On an access, each node along the path is set to point at the other
   // subtree, away from the accessed way.
   function automatic plru_vec_t plru_update(input plru_vec_t bits, input plru_way_t way,
                                             input int ways);
      logic [4:0] node;
      plru_way_t  w;
      plru_vec_t  nb;
      nb   = bits;
      node = '0;
      w    = way;
      for (int d = 0; d < PLRU_MAX_LEVELS; d++) begin
         if ((ways >> (d + 1)) != 0) begin
            nb[node] = ~w[0];
            node     = {node[3:0], 1'b0} + 5'd1 + {4'd0, w[0]};
            w        = w >> 1;
         end
      end
      return nb;
   endfunction

endpackage

// File: rtl/i_cache_nway_if.sv
// ----------------------------------------------------------------------------
// i_cache_nway_if
// Bundles the CPU fetch port, the flush handshake and the physical-memory
// fill port of the instruction cache.
//   mem_address/mem_read     CPU fetch request (held until mem_resp)
//   mem_rdata/mem_resp       fetched word and completion
//   flush/flush_done         invalidate-all request pulse and done pulse
//   pmem_address/pmem_read   line fill request (held until pmem_resp)
//   pmem_rdata/pmem_resp     line fill data and completion
// slave is the cache's view. master is the view of the CPU plus memory.
// ----------------------------------------------------------------------------
interface i_cache_nway_if;
   import i_cache_pkg::*;

   logic [31:0] mem_address;
   logic        mem_read;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        flush;
   logic        flush_done;
   logic [31:0] pmem_address;
   logic        pmem_read;
   line_t       pmem_rdata;
   logic        pmem_resp;

   modport slave (
      input  mem_address, mem_read, flush, pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp, flush_done, pmem_address, pmem_read
   );

   modport master (
      output mem_address, mem_read, flush, pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp, flush_done, pmem_address, pmem_read
   );

endinterface

// File: rtl/i_cache_plru.sv
// ----------------------------------------------------------------------------
// i_cache_plru
// Tree pseudo-LRU state for every set of the cache: num_ways-1 bits per set.
//   clk, rst      clock, synchronous active-low reset (clears all bits)
//   rd_set        set whose victim is reported on victim_way
//   victim_way    PLRU-selected way of rd_set
//   upd_en/upd_set/upd_way   mark upd_way of upd_set as most recently used
//   clr_en/clr_set           clear the PLRU bits of clr_set (flush)
// ----------------------------------------------------------------------------
module i_cache_plru
   import i_cache_pkg::*;
#(
   parameter int s_index  = 3,
   parameter int num_ways = 4,
   localparam int way_w   = $clog2(num_ways)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [s_index-1:0] rd_set,
   output logic [way_w-1:0]   victim_way,
   input  logic               upd_en,
   input  logic [s_index-1:0] upd_set,
   input  logic [way_w-1:0]   upd_way,
   input  logic               clr_en,
   input  logic [s_index-1:0] clr_set
);

   localparam int num_sets = 1 << s_index;

   logic [num_ways-2:0] bits_q [num_sets];

   plru_vec_t rd_vec;
   plru_vec_t upd_vec;
   plru_way_t upd_way_wide;

   // Widen the per-set bits into the package's fixed-size vector.
   always_comb begin
      rd_vec                     = '0;
      rd_vec[num_ways-2:0]       = bits_q[rd_set];
      upd_vec                    = '0;
      upd_vec[num_ways-2:0]      = bits_q[upd_set];
      upd_way_wide               = '0;
      upd_way_wide[way_w-1:0]    = upd_way;
   end

   assign victim_way = way_w'(plru_victim(rd_vec, num_ways));

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < num_sets; s++) begin
            bits_q[s] <= '0;
         end
      end else if (clr_en) begin
         bits_q[clr_set] <= '0;
      end else if (upd_en) begin
         bits_q[upd_set] <= (num_ways-1)'(plru_update(upd_vec, upd_way_wide, num_ways));
      end
   end

endmodule

// File: rtl/i_cache_nway.sv
// ----------------------------------------------------------------------------
// i_cache_nway
// Read-only N-way set-associative instruction cache with 32 B lines,
// tree pseudo-LRU replacement and a one-set-per-cycle invalidate-all engine.
//   clk   clock
//   rst   synchronous active-low reset
//   bus   i_cache_nway_if.slave: CPU fetch port, flush handshake and the
//         physical-memory line fill port
// Hits respond in the request cycle. Misses fill a victim way, then return
// to IDLE and hit on the re-lookup. Valid bits, PLRU bits and control state
// are reset. The tag and data arrays are not reset.
// ----------------------------------------------------------------------------
module i_cache_nway
   import i_cache_pkg::*;
#(
   parameter int s_offset  = 5,
   parameter int s_index   = 3,
   parameter int num_ways  = 4,
   localparam int s_tag    = 32 - s_offset - s_index
) (
   input logic            clk,
   input logic            rst,
   i_cache_nway_if.slave  bus
);

   localparam int num_sets = 1 << s_index;
   localparam int way_w    = $clog2(num_ways);

   // Control state
   state_t             state;
   logic [way_w-1:0]   victim_q;
   logic [s_index-1:0] flush_cnt;
   logic               flush_pend;
   logic               pmem_read_q;
   logic               flush_done_q;
   logic [num_ways-1:0] valid_q [num_sets];

   // Storage (not reset)
   logic [s_tag-1:0]   tag_q  [num_sets][num_ways];
   line_t              data_q [num_sets][num_ways];
   logic [31:0]        pmem_addr_q;

   // Lookup
   logic [s_tag-1:0]   req_tag;
   logic [s_index-1:0] req_idx;
   logic [2:0]         req_word;
   logic [num_ways-1:0] set_valid;
   logic [num_ways-1:0] hit_vec;
   logic               hit;
   logic [way_w-1:0]   hit_way;
   line_t              hit_line;
   logic [way_w-1:0]   inv_way;
   logic               has_inv;
   logic [way_w-1:0]   plru_way;
   logic [way_w-1:0]   victim_sel;

   logic flush_req;
   logic idle_hit;
   logic miss_start;
   logic fill_done;
   logic unused_addr;

   assign req_tag   = bus.mem_address[31 -: s_tag];
   assign req_idx   = bus.mem_address[s_offset +: s_index];
   assign req_word  = bus.mem_address[4:2];
   assign set_valid = valid_q[req_idx];

   // Byte lane bits are never used for word fetches.
   assign unused_addr = &{1'b0, bus.mem_address[1:0]};

   always_comb begin
      hit_vec = '0;
      for (int w = 0; w < num_ways; w++) begin
         hit_vec[w] = set_valid[w] && (tag_q[req_idx][w] == req_tag);
      end
   end

   assign hit = |hit_vec;

   // OR-style encode is enough because at most one way can hit.
   always_comb begin
      hit_way = '0;
      for (int w = 0; w < num_ways; w++) begin
         if (hit_vec[w]) hit_way = way_w'(w);
      end
   end

   assign hit_line = data_q[req_idx][hit_way];

   // Lowest-index invalid way; scanning downward leaves the smallest one.
   always_comb begin
      inv_way = '0;
      for (int w = num_ways - 1; w >= 0; w--) begin
         if (!set_valid[w]) inv_way = way_w'(w);
      end
   end

   assign has_inv    = ~&set_valid;
   assign victim_sel = has_inv ? inv_way : plru_way;

   // A pending flush from FILL takes the same priority as a fresh pulse.
   assign flush_req  = bus.flush || flush_pend;
   assign idle_hit   = (state == IDLE) && bus.mem_read && hit && !flush_req;
   assign miss_start = (state == IDLE) && bus.mem_read && !hit && !flush_req;
   assign fill_done  = rst && (state == FILL) && bus.pmem_resp;

   assign bus.mem_resp     = idle_hit;
   assign bus.mem_rdata    = hit_line[{req_word, 5'b0} +: 32];
   assign bus.pmem_read    = pmem_read_q;
   assign bus.pmem_address = pmem_addr_q;
   assign bus.flush_done   = flush_done_q;

   i_cache_plru #(
      .s_index  (s_index),
      .num_ways (num_ways)
   ) u_plru (
      .clk        (clk),
      .rst        (rst),
      .rd_set     (req_idx),
      .victim_way (plru_way),
      .upd_en     (idle_hit || fill_done),
      .upd_set    (req_idx),
      .upd_way    ((state == FILL) ? victim_q : hit_way),
      .clr_en     (state == FLUSH),
      .clr_set    (flush_cnt)
   );

   // Controller
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         victim_q     <= '0;
         flush_cnt    <= '0;
         flush_pend   <= 1'b0;
         pmem_read_q  <= 1'b0;
         flush_done_q <= 1'b0;
         for (int s = 0; s < num_sets; s++) begin
            valid_q[s] <= '0;
         end
      end else begin
         flush_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (flush_req) begin
                  state      <= FLUSH;
                  flush_cnt  <= '0;
                  flush_pend <= 1'b0;
               end else if (miss_start) begin
                  state       <= FILL;
                  victim_q    <= victim_sel;
                  pmem_read_q <= 1'b1;
               end
            end
            FILL: begin
               if (bus.flush) flush_pend <= 1'b1;
               if (bus.pmem_resp) begin
                  pmem_read_q                <= 1'b0;
                  valid_q[req_idx][victim_q] <= 1'b1;
                  state                      <= IDLE;
               end
            end
            FLUSH: begin
               valid_q[flush_cnt] <= '0;
               if (&flush_cnt) begin
                  state        <= IDLE;
                  flush_done_q <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line storage and fill address
   always_ff @(posedge clk) begin
      if (miss_start) begin
         pmem_addr_q <= {bus.mem_address[31:s_offset], {s_offset{1'b0}}};
      end
      if (fill_done) begin
         data_q[req_idx][victim_q] <= bus.pmem_rdata;
         tag_q[req_idx][victim_q]  <= req_tag;
      end
   end

   // A line can only be filled after a miss, so two ways never share a tag.
   multi_hit_a: assert property (@(posedge clk) disable iff (!rst)
      bus.mem_read |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_i_cache_nway.sv
// ----------------------------------------------------------------------------
// tb_i_cache_nway
// Directed bench for i_cache_nway (4 ways, 8 sets, 32 B lines). A small
// memory model answers fills after a chosen number of pmem_read cycles.
// Line contents come from word_of(), so every expected word is known here.
// ----------------------------------------------------------------------------
module tb_i_cache_nway;
   import i_cache_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   i_cache_nway_if bus ();

   i_cache_nway #(
      .s_offset (5),
      .s_index  (3),
      .num_ways (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total  = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] base, input int i);
      if (base == 32'h40 && i == 0) return 32'hDEAD_BEEF;
      return (base + 32'(i * 4)) ^ 32'hC0DE_0000;
   endfunction

   function automatic line_t mk_line(input logic [31:0] base);
      line_t l;
      l = '0;
      for (int i = 0; i < 8; i++) l = {word_of(base, i), l[255:32]};
      return l;
   endfunction

   // Issues one fetch starting just after a falling edge and serves any fills.
   // cyc counts cycles from the request cycle (1) to the mem_resp cycle.
   task automatic cpu_read(input logic [31:0] addr, input int lat, input int flush_at,
                           output logic [31:0] data, output int cyc, output int fills,
                           output int dones, output int preads, output logic addr_ok);
      int          pcyc;
      logic        got;
      logic [31:0] line_a;
      line_a = {addr[31:5], 5'b0};
      bus.mem_address = addr;
      bus.mem_read    = 1'b1;
      cyc = 0; fills = 0; dones = 0; preads = 0; pcyc = 0; got = 1'b0;
      addr_ok = 1'b1; data = '0;
      while (!got && cyc < 200) begin
         cyc++;
         #1;
         if (bus.flush_done) dones++;
         if (bus.mem_resp) begin
            got  = 1'b1;
            data = bus.mem_rdata;
         end
         if (bus.pmem_read) begin
            if (pcyc == 0) fills++;
            pcyc++;
            preads++;
            if (bus.pmem_address !== line_a) addr_ok = 1'b0;
            if (pcyc == lat) begin
               bus.pmem_resp  = 1'b1;
               bus.pmem_rdata = mk_line(line_a);
            end
         end else begin
            pcyc = 0;
         end
         if (flush_at != 0 && cyc == flush_at) bus.flush = 1'b1;
         @(negedge clk);
         bus.pmem_resp = 1'b0;
         bus.flush     = 1'b0;
      end
      bus.mem_read = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          cyc, fills, dones, preads, n;
      logic        aok, seen;

      rst = 1'b0;
      bus.mem_address = '0;
      bus.mem_read    = 1'b0;
      bus.flush       = 1'b0;
      bus.pmem_resp   = 1'b0;
      bus.pmem_rdata  = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_resp",   32'(bus.mem_resp),   32'd0);
      chk("rst_pmem_read",  32'(bus.pmem_read),  32'd0);
      chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Cold miss, memory answers in the 3rd pmem_read cycle
      cpu_read(32'h40, 3, 0, d, cyc, fills, dones, preads, aok);
      chk("cold_data",   d,            32'hDEAD_BEEF);
      chk("cold_cycles", 32'(cyc),     32'd5);
      chk("cold_preads", 32'(preads),  32'd3);
      chk("cold_addr",   32'(aok),     32'd1);
      cpu_read(32'h40, 3, 0, d, cyc, fills, dones, preads, aok);
      chk("rehit_data",   d,           32'hDEAD_BEEF);
      chk("rehit_cycles", 32'(cyc),    32'd1);
      chk("rehit_fills",  32'(fills),  32'd0);

      // Word select within line 0x100
      cpu_read(32'h100, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("w_fill_cycles", 32'(cyc), 32'd4);
      chk("w_fill_addr",   32'(aok), 32'd1);
      for (int i = 0; i < 8; i++) begin
         cpu_read(32'h100 + 32'(4 * i), 2, 0, d, cyc, fills, dones, preads, aok);
         chk("word_data",   d,        word_of(32'h100, i));
         chk("word_cycles", 32'(cyc), 32'd1);
      end

      // Replacement in set 1: fill ways 0..3, touch way0, fill a 5th line
      for (int k = 0; k < 4; k++) begin
         cpu_read(32'h1020 + 32'(k << 12), 2, 0, d, cyc, fills, dones, preads, aok);
         chk("repl_fill", 32'(fills), 32'd1);
      end
      cpu_read(32'h1020, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("repl_touch0", 32'(cyc), 32'd1);
      cpu_read(32'h5020, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("repl_fill5",  32'(fills), 32'd1);
      chk("repl_data5",  d,          word_of(32'h5020, 0));
      cpu_read(32'h1020, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("repl_hit_a", 32'(cyc), 32'd1);
      cpu_read(32'h3020, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("repl_hit_c", 32'(cyc), 32'd1);
      cpu_read(32'h4020, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("repl_hit_d", 32'(cyc), 32'd1);
      cpu_read(32'h5020, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("repl_hit_e", 32'(cyc), 32'd1);
      cpu_read(32'h2020, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("repl_evicted_miss", 32'(fills), 32'd1);
      chk("repl_evicted_data", d,          word_of(32'h2020, 0));

      // Flush while IDLE, with a fetch held during the flush
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush       = 1'b0;
      bus.mem_address = 32'h40;
      bus.mem_read    = 1'b1;
      n = 0;
      seen = 1'b0;
      while (n < 50) begin
         #1;
         if (bus.flush_done) break;
         if (bus.mem_resp) seen = 1'b1;
         n++;
         @(negedge clk);
      end
      chk("flush_cycles",       32'(n),            32'd8);
      chk("flush_no_resp",      32'(seen),         32'd0);
      chk("flush_done_no_resp", 32'(bus.mem_resp), 32'd0);
      @(negedge clk);
      #1;
      chk("flush_done_pulse", 32'(bus.flush_done), 32'd0);
      cpu_read(32'h40, 3, 0, d, cyc, fills, dones, preads, aok);
      chk("flush_held_miss",   32'(fills), 32'd1);
      chk("flush_held_cycles", 32'(cyc),   32'd4);
      chk("flush_held_data",   d,          32'hDEAD_BEEF);
      cpu_read(32'h100, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("flush_miss_100",  32'(fills), 32'd1);
      cpu_read(32'h1020, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("flush_miss_1020", 32'(fills), 32'd1);

      // Flush raised in the first FILL cycle
      cpu_read(32'h200, 3, 2, d, cyc, fills, dones, preads, aok);
      chk("ffill_fills",  32'(fills), 32'd2);
      chk("ffill_dones",  32'(dones), 32'd1);
      chk("ffill_cycles", 32'(cyc),   32'd18);
      chk("ffill_data",   d,          word_of(32'h200, 0));
      cpu_read(32'h100, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("ffill_miss_100", 32'(fills), 32'd1);

      // Reset in the middle of a fill, with memory answering during reset
      bus.mem_address = 32'h40;
      bus.mem_read    = 1'b1;
      #1;
      chk("rfill_idle_pread", 32'(bus.pmem_read), 32'd0);
      @(negedge clk);
      #1;
      chk("rfill_pread",   32'(bus.pmem_read), 32'd1);
      chk("rfill_resp_fill", 32'(bus.mem_resp), 32'd0);
      rst            = 1'b0;
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = {8{32'h0BAD_0BAD}};
      @(negedge clk);
      #1;
      chk("rfill_pread_drop", 32'(bus.pmem_read), 32'd0);
      chk("rfill_resp_rst",   32'(bus.mem_resp),  32'd0);
      rst           = 1'b1;
      bus.mem_read  = 1'b0;
      bus.pmem_resp = 1'b0;
      @(negedge clk);
      cpu_read(32'h40, 3, 0, d, cyc, fills, dones, preads, aok);
      chk("rfill_post_miss", 32'(fills), 32'd1);
      chk("rfill_post_data", d,          32'hDEAD_BEEF);
      cpu_read(32'h200, 2, 0, d, cyc, fills, dones, preads, aok);
      chk("rfill_post_miss_200", 32'(fills), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
